// File: rtl/axis_fifo_pkg.sv
// axis_fifo_pkg: shared types and helpers for the AXI-Stream packet FIFO.
// The beat layout itself depends on module parameters; this package sizes it.
package axis_fifo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        DROP
    } wr_state_e;

    // data + keep + strb + last + id + dest + user
    function automatic int beat_width(
        input int dw,
        input int iw,
        input int tw,
        input int uw
    );
        return dw + 2 * (dw / 8) + 1 + iw + tw + uw;
    endfunction

    function automatic logic [31:0] ptr_diff(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          pw
    );
        logic [31:0] m;
        m = (32'd1 << pw) - 32'd1;
        return (a - b) & m;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// axis_fifo_ram: simple dual-port storage with a registered read port.
// The FIFO never reads the slot it is writing, so collision order is moot.
module axis_fifo_ram
    import axis_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: AXI-Stream FIFO, cut-through or store-and-forward.
// Bad or oversized packets are rolled back before they ever become visible.
module axis_packet_fifo
    import axis_fifo_pkg::*;
#(
    parameter int TDATA_WIDTH = 64,
    parameter int TID_WIDTH   = 4,
    parameter int TDEST_WIDTH = 4,
    parameter int TUSER_WIDTH = 1,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 1,
    parameter int DROP_BAD    = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_s_axis_tvalid,
    output logic                       o_s_axis_tready,
    input  logic [TDATA_WIDTH-1:0]     i_s_axis_tdata,
    input  logic [TDATA_WIDTH/8-1:0]   i_s_axis_tkeep,
    input  logic [TDATA_WIDTH/8-1:0]   i_s_axis_tstrb,
    input  logic                       i_s_axis_tlast,
    input  logic [TID_WIDTH-1:0]       i_s_axis_tid,
    input  logic [TDEST_WIDTH-1:0]     i_s_axis_tdest,
    input  logic [TUSER_WIDTH-1:0]     i_s_axis_tuser,
    output logic                       o_m_axis_tvalid,
    input  logic                       i_m_axis_tready,
    output logic [TDATA_WIDTH-1:0]     o_m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0]   o_m_axis_tkeep,
    output logic [TDATA_WIDTH/8-1:0]   o_m_axis_tstrb,
    output logic                       o_m_axis_tlast,
    output logic [TID_WIDTH-1:0]       o_m_axis_tid,
    output logic [TDEST_WIDTH-1:0]     o_m_axis_tdest,
    output logic [TUSER_WIDTH-1:0]     o_m_axis_tuser,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic [$clog2(DEPTH):0]     o_pkt_count,
    output logic                       o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int KW = TDATA_WIDTH / 8;
    localparam int BW = beat_width(TDATA_WIDTH, TID_WIDTH,
                                   TDEST_WIDTH, TUSER_WIDTH);

    typedef struct packed {
        logic [TDATA_WIDTH-1:0] data;
        logic [KW-1:0]          keep;
        logic [KW-1:0]          strb;
        logic                   last;
        logic [TID_WIDTH-1:0]   id;
        logic [TDEST_WIDTH-1:0] dest;
        logic [TUSER_WIDTH-1:0] user;
    } beat_t;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0
        || TDATA_WIDTH % 8 != 0 || $bits(beat_t) != BW) begin : g_bad_param
        $error("axis_packet_fifo: illegal parameter set");
    end

    wr_state_e     r_state;
    wr_state_e     w_state_nxt;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_commit_ptr;
    logic [PW-1:0] r_fetch_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_pkt_cnt;
    logic [PW-1:0] w_wr_nxt;
    logic [PW-1:0] w_commit_nxt;
    logic [PW-1:0] w_pkt_nxt;
    logic [PW-1:0] w_vis_ptr;
    logic [PW-1:0] w_used;
    logic [PW-1:0] w_pend;
    logic          r_rdy_en;
    logic          r_drop;
    logic          r_rd_valid;
    logic          w_full;
    logic          w_wr_hs;
    logic          w_m_hs;
    logic          w_err;
    logic          w_mem_we;
    logic          w_commit_ev;
    logic          w_drop_ev;
    logic          w_fetch;
    logic          w_pkt_dec;
    logic [1:0]    w_infl;

    beat_t      w_in_beat;
    beat_t      w_rd_beat;
    beat_t      w_head;
    beat_t      r_ob [2];
    logic       r_ob_wr;
    logic       r_ob_rd;
    logic [1:0] r_ob_cnt;

    assign w_in_beat = '{
        data: i_s_axis_tdata,
        keep: i_s_axis_tkeep,
        strb: i_s_axis_tstrb,
        last: i_s_axis_tlast,
        id:   i_s_axis_tid,
        dest: i_s_axis_tdest,
        user: i_s_axis_tuser
    };

    // rd_ptr frees a slot only at the master handshake, so beats parked
    // in the output stage still count against capacity and o_level.
    assign w_vis_ptr = (PACKET_MODE != 0) ? r_commit_ptr : r_wr_ptr;
    assign w_used = PW'(ptr_diff(32'(r_wr_ptr), 32'(r_rd_ptr), PW));
    assign w_pend = PW'(ptr_diff(32'(r_wr_ptr), 32'(r_commit_ptr), PW));
    assign w_full = (w_used == PW'(DEPTH));
    assign w_err = (DROP_BAD != 0) && i_s_axis_tuser[0];

    assign o_s_axis_tready = r_rdy_en && (r_state == DROP || !w_full);
    assign w_wr_hs = i_s_axis_tvalid && o_s_axis_tready;

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_nxt     = r_wr_ptr;
        w_commit_nxt = r_commit_ptr;
        w_mem_we     = 1'b0;
        w_commit_ev  = 1'b0;
        w_drop_ev    = 1'b0;
        if (PACKET_MODE == 0) begin
            if (w_wr_hs) begin
                w_mem_we = 1'b1;
                w_wr_nxt = r_wr_ptr + PW'(1);
            end
            w_commit_nxt = w_wr_nxt;
        end else begin
            unique case (r_state)
                IDLE, ACCEPT: begin
                    if (w_wr_hs) begin
                        if (i_s_axis_tlast && w_err) begin
                            w_wr_nxt    = r_commit_ptr;
                            w_drop_ev   = 1'b1;
                            w_state_nxt = IDLE;
                        end else if (i_s_axis_tlast) begin
                            w_mem_we     = 1'b1;
                            w_wr_nxt     = r_wr_ptr + PW'(1);
                            w_commit_nxt = r_wr_ptr + PW'(1);
                            w_commit_ev  = 1'b1;
                            w_state_nxt  = IDLE;
                        end else if (w_pend == PW'(DEPTH - 1)) begin
                            // Filling the last slot without tlast: the
                            // packet can never fit, so shed it now and
                            // keep the slave side flowing.
                            w_wr_nxt    = r_commit_ptr;
                            w_state_nxt = DROP;
                        end else begin
                            w_mem_we    = 1'b1;
                            w_wr_nxt    = r_wr_ptr + PW'(1);
                            w_state_nxt = ACCEPT;
                        end
                    end
                end
                DROP: begin
                    if (w_wr_hs && i_s_axis_tlast) begin
                        w_drop_ev   = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // In-flight count keeps RAM reads from overrunning the 2-entry stage.
    assign w_m_hs  = o_m_axis_tvalid && i_m_axis_tready;
    assign w_infl  = r_ob_cnt + {1'b0, r_rd_valid};
    assign w_fetch = (r_fetch_ptr != w_vis_ptr)
                  && (w_infl < 2'd2 || w_m_hs);

    axis_fifo_ram #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_mem_we),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (w_in_beat),
        .i_re    (w_fetch),
        .i_raddr (r_fetch_ptr[AW-1:0]),
        .o_rdata (w_rd_beat)
    );

    assign w_pkt_dec = (PACKET_MODE != 0) && w_m_hs && o_m_axis_tlast;

    always_comb begin
        w_pkt_nxt = r_pkt_cnt;
        if (w_commit_ev && !w_pkt_dec) begin
            w_pkt_nxt = r_pkt_cnt + PW'(1);
        end else if (!w_commit_ev && w_pkt_dec) begin
            w_pkt_nxt = r_pkt_cnt - PW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_fetch_ptr  <= '0;
            r_rd_ptr     <= '0;
            r_pkt_cnt    <= '0;
            r_rdy_en     <= 1'b0;
            r_drop       <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_ob[0]      <= '0;
            r_ob[1]      <= '0;
            r_ob_wr      <= 1'b0;
            r_ob_rd      <= 1'b0;
            r_ob_cnt     <= 2'd0;
        end else begin
            r_rdy_en     <= 1'b1;
            r_state      <= w_state_nxt;
            r_wr_ptr     <= w_wr_nxt;
            r_commit_ptr <= w_commit_nxt;
            r_fetch_ptr  <= r_fetch_ptr + PW'(w_fetch);
            r_rd_ptr     <= r_rd_ptr + PW'(w_m_hs);
            r_pkt_cnt    <= w_pkt_nxt;
            r_drop       <= w_drop_ev;
            r_rd_valid   <= w_fetch;
            if (r_rd_valid) begin
                r_ob[r_ob_wr] <= w_rd_beat;
                r_ob_wr       <= ~r_ob_wr;
            end
            if (w_m_hs) begin
                r_ob_rd <= ~r_ob_rd;
            end
            r_ob_cnt <= r_ob_cnt + {1'b0, r_rd_valid} - {1'b0, w_m_hs};
        end
    end

    assign w_head          = r_ob[r_ob_rd];
    assign o_m_axis_tvalid = (r_ob_cnt != 2'd0);
    assign o_m_axis_tdata  = w_head.data;
    assign o_m_axis_tkeep  = w_head.keep;
    assign o_m_axis_tstrb  = w_head.strb;
    assign o_m_axis_tlast  = w_head.last;
    assign o_m_axis_tid    = w_head.id;
    assign o_m_axis_tdest  = w_head.dest;
    assign o_m_axis_tuser  = w_head.user;
    assign o_level         = w_used;
    assign o_pkt_count     = r_pkt_cnt;
    assign o_drop          = r_drop;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// tb_axis_packet_fifo: directed scoreboard bench over three FIFO builds:
// stream/16, packet/16 and packet/8, one active at a time via sel.
module tb_axis_packet_fifo;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic [7:0]  s;
        logic        l;
        logic [3:0]  i;
        logic [3:0]  t;
        logic [0:0]  u;
    } tb_beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          sel;
    logic        s_valid;
    logic [63:0] s_data;
    logic [7:0]  s_keep;
    logic [7:0]  s_strb;
    logic        s_last;
    logic [3:0]  s_id;
    logic [3:0]  s_dest;
    logic [0:0]  s_user;
    logic        m_ready [3];

    logic        s_ready [3];
    logic        m_valid [3];
    logic [63:0] m_data  [3];
    logic [7:0]  m_keep  [3];
    logic [7:0]  m_strb  [3];
    logic        m_last  [3];
    logic [3:0]  m_id    [3];
    logic [3:0]  m_dest  [3];
    logic [0:0]  m_user  [3];
    logic [4:0]  lvl     [3];
    logic [4:0]  pc      [3];
    logic        drp     [3];

    tb_beat_t sb [$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_out, first_out, last_out, first_v, max_lvl;
    int n_drop, drop_cyc, acc_cyc, stalls, t0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int D  = (g == 2) ? 8 : 16;
        localparam int PM = (g == 0) ? 0 : 1;
        logic [$clog2(D):0] w_lvl;
        logic [$clog2(D):0] w_pc;
        axis_packet_fifo #(
            .TDATA_WIDTH (64),
            .TID_WIDTH   (4),
            .TDEST_WIDTH (4),
            .TUSER_WIDTH (1),
            .DEPTH       (D),
            .PACKET_MODE (PM),
            .DROP_BAD    (1)
        ) u_dut (
            .i_clk           (clk),
            .i_rst_n         (rst_n),
            .i_s_axis_tvalid (s_valid && (sel == g)),
            .o_s_axis_tready (s_ready[g]),
            .i_s_axis_tdata  (s_data),
            .i_s_axis_tkeep  (s_keep),
            .i_s_axis_tstrb  (s_strb),
            .i_s_axis_tlast  (s_last),
            .i_s_axis_tid    (s_id),
            .i_s_axis_tdest  (s_dest),
            .i_s_axis_tuser  (s_user),
            .o_m_axis_tvalid (m_valid[g]),
            .i_m_axis_tready (m_ready[g]),
            .o_m_axis_tdata  (m_data[g]),
            .o_m_axis_tkeep  (m_keep[g]),
            .o_m_axis_tstrb  (m_strb[g]),
            .o_m_axis_tlast  (m_last[g]),
            .o_m_axis_tid    (m_id[g]),
            .o_m_axis_tdest  (m_dest[g]),
            .o_m_axis_tuser  (m_user[g]),
            .o_level         (w_lvl),
            .o_pkt_count     (w_pc),
            .o_drop          (drp[g])
        );
        assign lvl[g] = 5'(w_lvl);
        assign pc[g]  = 5'(w_pc);
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sampled on the falling edge; a handshake seen here lands next rise.
    always @(negedge clk) begin
        tb_beat_t got;
        tb_beat_t exp;
        if (rst_n) begin
            if (m_valid[sel] && first_v < 0) first_v = cyc;
            if (int'(lvl[sel]) > max_lvl) max_lvl = int'(lvl[sel]);
            if (drp[sel]) begin
                n_drop++;
                drop_cyc = cyc;
            end
            if (m_valid[sel] && m_ready[sel]) begin
                got = {m_data[sel], m_keep[sel], m_strb[sel], m_last[sel],
                       m_id[sel], m_dest[sel], m_user[sel]};
                if (sb.size() == 0) begin
                    chk("extra_beat", 128'(m_valid[sel]), 128'd0);
                end else begin
                    exp = sb.pop_front();
                    chk("beat", 128'(got), 128'(exp));
                    if (n_out == 0) first_out = cyc;
                    last_out = cyc;
                    n_out++;
                end
            end
        end
    end

    task automatic send(input logic [63:0] d, input logic l,
                        input logic u, input bit keep_it);
        int t;
        tb_beat_t b;
        t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = d[7:0];
        s_strb  = d[15:8];
        s_id    = d[19:16];
        s_dest  = d[23:20];
        s_last  = l;
        s_user  = u;
        b = {d, d[7:0], d[15:8], l, d[19:16], d[23:20], u};
        @(negedge clk);
        while (!s_ready[sel] && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            chk("send_timeout", 128'(s_ready[sel]), 128'd1);
        end else begin
            if (t != 0) stalls++;
            acc_cyc = cyc + 1;
            if (keep_it) sb.push_back(b);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 128'(sb.size()), 128'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        n_out = 0;
        first_out = 0;
        last_out = 0;
        first_v = -1;
        max_lvl = 0;
        n_drop = 0;
        drop_cyc = -1;
        stalls = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 0;
        s_valid = 1'b0;
        s_data = '0;
        s_keep = '0;
        s_strb = '0;
        s_last = 1'b0;
        s_id = '0;
        s_dest = '0;
        s_user = '0;
        m_ready = '{1'b1, 1'b1, 1'b1};
        clear_stats();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", 128'(s_ready[0]), 128'd0);
        chk("rst_tvalid", 128'(m_valid[1]), 128'd0);
        chk("rst_level", 128'(lvl[0]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_after_rst", 128'(s_ready[0]), 128'd1);

        // stream, back-to-back, sink always ready
        sel = 0;
        clear_stats();
        for (int i = 0; i < 20; i++) begin
            send({$urandom(), $urandom()}, i == 19, 1'b0, 1'b1);
            if (i == 0) t0 = acc_cyc;
        end
        drain("s1_drain");
        chk("s1_latency", 128'(first_v - t0), 128'd2);
        chk("s1_count", 128'(n_out), 128'd20);
        chk("s1_nobubble", 128'(last_out - first_out), 128'd19);
        chk("s1_level_le3", 128'(max_lvl <= 3), 128'd1);

        // stream, sink stalled until full
        clear_stats();
        m_ready[0] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send({$urandom(), $urandom()}, i[2], 1'b0, 1'b1);
        end
        chk("s2_tready", 128'(s_ready[0]), 128'd0);
        chk("s2_level", 128'(lvl[0]), 128'd16);
        chk("s2_tvalid", 128'(m_valid[0]), 128'd1);
        m_ready[0] = 1'b1;
        drain("s2_drain");
        chk("s2_count", 128'(n_out), 128'd16);
        chk("s2_level0", 128'(lvl[0]), 128'd0);

        // packet mode, 5-beat packet held until tlast
        sel = 1;
        clear_stats();
        for (int i = 0; i < 5; i++) begin
            send({$urandom(), $urandom()}, i == 4, 1'b0, 1'b1);
        end
        t0 = acc_cyc;
        chk("p1_pktcnt1", 128'(pc[1]), 128'd1);
        drain("p1_drain");
        chk("p1_latency", 128'(first_v - t0), 128'd2);
        chk("p1_pktcnt0", 128'(pc[1]), 128'd0);
        chk("p1_count", 128'(n_out), 128'd5);

        // error-marked packet followed by a good one
        clear_stats();
        for (int i = 0; i < 4; i++) begin
            send({$urandom(), $urandom()}, i == 3, i == 3, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            send({$urandom(), $urandom()}, i == 2, 1'b0, 1'b1);
        end
        drain("p2_drain");
        chk("p2_drops", 128'(n_drop), 128'd1);
        chk("p2_count", 128'(n_out), 128'd3);
        chk("p2_level0", 128'(lvl[1]), 128'd0);

        // oversized packet on the 8-deep build
        sel = 2;
        clear_stats();
        for (int i = 0; i < 12; i++) begin
            send({$urandom(), $urandom()}, i == 11, 1'b0, 1'b0);
        end
        t0 = acc_cyc;
        for (int i = 0; i < 2; i++) begin
            send({$urandom(), $urandom()}, i == 1, 1'b0, 1'b1);
        end
        drain("p3_drain");
        chk("p3_stalls", 128'(stalls), 128'd0);
        chk("p3_drops", 128'(n_drop), 128'd1);
        chk("p3_drop_at12", 128'(drop_cyc), 128'(t0));
        chk("p3_count", 128'(n_out), 128'd2);
        chk("p3_level0", 128'(lvl[2]), 128'd0);

        // reset with one committed packet and one partial beat held
        sel = 1;
        clear_stats();
        m_ready[1] = 1'b0;
        send({$urandom(), $urandom()}, 1'b0, 1'b0, 1'b0);
        send({$urandom(), $urandom()}, 1'b1, 1'b0, 1'b0);
        send({$urandom(), $urandom()}, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("r_level3", 128'(lvl[1]), 128'd3);
        chk("r_valid_pre", 128'(m_valid[1]), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_tvalid", 128'(m_valid[1]), 128'd0);
        chk("r_tready", 128'(s_ready[1]), 128'd0);
        chk("r_level", 128'(lvl[1]), 128'd0);
        chk("r_pktcnt", 128'(pc[1]), 128'd0);
        chk("r_drop", 128'(drp[1]), 128'd0);
        chk("r_tdata", 128'(m_data[1]), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("r_post_level", 128'(lvl[1]), 128'd0);
        chk("r_post_valid", 128'(m_valid[1]), 128'd0);
        m_ready[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            send({$urandom(), $urandom()}, i == 1, 1'b0, 1'b1);
        end
        drain("r_drain");
        chk("r_count", 128'(n_out), 128'd2);
        chk("r_pktcnt0", 128'(pc[1]), 128'd0);

        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axis_packet_fifo.md
Name: axis_packet_fifo

Overview:
- Parametrised synchronous AXI-Stream FIFO with byte-wide tkeep/tstrb and vector tid/tdest/tuser.
- Two modes, selected by parameter:
  - Stream mode: cut-through.
  - Packet mode: store-and-forward. A packet's beats are released only after its tlast beat is written. Oversized packets and error-marked packets are dropped whole.
- Sits between MAC/parser stages and downstream consumers, giving elastic buffering and bad-frame removal.

Parameters:
- TDATA_WIDTH, 64, data width in bits; multiple of 8.
- TID_WIDTH, 4, tid width; at least 1.
- TDEST_WIDTH, 4, tdest width; at least 1.
- TUSER_WIDTH, 1, tuser width; bit 0 is the error flag.
- DEPTH, 16, entries; power of two, at least 4. Elaboration error otherwise.
- PACKET_MODE, 1, 1 = store-and-forward, 0 = cut-through.
- DROP_BAD, 1, packet mode only: drop a packet whose tlast beat has tuser[0]=1.

Ports:
- i_clk, in, 1, clock.
- i_rst_n, in, 1, reset, asynchronous, active-low.
- Slave (input) side:
  - i_s_axis_tvalid, in, 1, input beat valid.
  - o_s_axis_tready, out, 1, input beat accepted when high with tvalid.
  - i_s_axis_tdata, in, TDATA_WIDTH, data.
  - i_s_axis_tkeep, in, TDATA_WIDTH/8, byte keep.
  - i_s_axis_tstrb, in, TDATA_WIDTH/8, byte strobe.
  - i_s_axis_tlast, in, 1, end of packet.
  - i_s_axis_tid, in, TID_WIDTH, stream id.
  - i_s_axis_tdest, in, TDEST_WIDTH, routing.
  - i_s_axis_tuser, in, TUSER_WIDTH, sideband; bit 0 = error.
- Master (output) side:
  - o_m_axis_tvalid, in/out pair: o_m_axis_tvalid out, 1; i_m_axis_tready in, 1.
  - o_m_axis_tdata / tkeep / tstrb / tlast / tid / tdest / tuser: out, same widths as the slave side.
- Status:
  - o_level, out, $clog2(DEPTH)+1, entries written (committed + pending).
  - o_pkt_count, out, $clog2(DEPTH)+1, complete packets held (packet mode; 0 in stream mode).
  - o_drop, out, 1, one-cycle pulse per dropped packet.

Behaviour:
- Reset (async assert, sync-release use):
  - All pointers = 0.
  - o_m_axis_tvalid=0, o_s_axis_tready=0, o_level=0, o_pkt_count=0, o_drop=0.
  - o_s_axis_tready goes to 1 on the first clock after release.
  - Reset mid-packet discards all contents, including partial packets.
- Pointers:
  - wr_ptr, commit_ptr and rd_ptr are $clog2(DEPTH)+1 bits; the extra MSB resolves wrap.
  - empty = (rd_ptr == visible_ptr), where visible_ptr = commit_ptr in packet mode, else wr_ptr.
  - full = (wr_ptr - rd_ptr == DEPTH). All DEPTH entries are usable.
- Input:
  - o_s_axis_tready = !full, except in state DROP, where it is 1.
  - A beat is written on tvalid & tready; wr_ptr increments.
- Write state machine (packet mode):
  - IDLE: first accepted beat -> ACCEPT. A single-beat packet is committed immediately.
  - ACCEPT, tlast accepted, tuser[0]=0 or DROP_BAD=0: commit_ptr <= wr_ptr+1; o_pkt_count++ -> IDLE.
  - ACCEPT, tlast accepted, tuser[0]=1 and DROP_BAD=1: wr_ptr <= commit_ptr; o_drop pulse -> IDLE.
  - ACCEPT, full and the packet started at rd_ptr (wr_ptr - commit_ptr == DEPTH, packet can never fit): wr_ptr <= commit_ptr -> DROP.
  - DROP: beats accepted and discarded; on tlast, o_drop pulse -> IDLE.
- Stream mode: no state machine; commit_ptr tracks wr_ptr.
- Memory and output pipeline:
  - Memory is simple dual-port with a registered read.
  - The output stage is a 2-entry skid buffer and holds master outputs stable while tvalid & !tready (AXI rule: tvalid never drops without a handshake).
  - Latency: a beat accepted (stream mode) or committed (packet mode) at edge k into an empty FIFO gives o_m_axis_tvalid=1 after edge k+2.
  - Sustained 1 beat/cycle on both sides when not full or empty.
- Simultaneous events:
  - Write and read in the same cycle: o_level unchanged.
  - Commit and a final-beat read in the same cycle: o_pkt_count unchanged.
  - Rollback never touches entries at or below commit_ptr.
- o_pkt_count decrements on a master handshake with tlast=1.

Decomposition:
- Package axis_fifo_pkg:
  - typedef of the packed beat struct (data, keep, strb, last, id, dest, user), parameterised via a width-function helper.
  - write-FSM enum {IDLE, ACCEPT, DROP}.
  - function ptr_diff().
- Sub-module axis_fifo_ram: simple dual-port, registered read, write-first irrelevant because addresses are never equal on a valid read.

Test Plan:
- Stream mode, DEPTH=16: 20 back-to-back beats with i_m_axis_tready=1 -> output matches input in order; first tvalid 2 cycles after the first accept; no bubbles; o_level ≤ 3.
- Stream mode, tready=0: 16 beats -> o_s_axis_tready=0 after the 16th, o_level=16. Release tready -> all 16 beats out unchanged, no loss or duplication.
- Packet mode: a 5-beat packet with tready=1 -> o_m_axis_tvalid stays 0 until 2 cycles after tlast is accepted; o_pkt_count=1, then 0 after the tlast handshake.
- Packet mode, DROP_BAD=1: a 4-beat packet with tuser[0]=1 on tlast, followed by a good 3-beat packet -> one o_drop pulse; only the 3 good beats are emitted; o_level returns to 0.
- Packet mode, DEPTH=8: a 12-beat packet -> tready stays 1 throughout; one o_drop pulse at beat 12; no output; a following 2-beat packet passes intact.
- Reset asserted mid-packet with 3 entries held -> all outputs 0 immediately; after release the FIFO is empty and the next packet passes correctly.
